// File: rtl/alu_mdu_if.sv
// Request/result bundle for the alu_mdu execute unit.
// Handshake: a request moves when valid_i && ready_o on a rising clk edge
// (flush_i in that cycle cancels it); a result moves when valid_o && ready_i.
// A producer holds its valid and payload steady until the transfer happens.
interface alu_mdu_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
);
   logic              valid_i;
   logic              ready_o;
   logic [AWIDTH-1:0] pc_i;
   logic [DWIDTH-1:0] rs1_i;
   logic [DWIDTH-1:0] rs2_i;
   logic [DWIDTH-1:0] imm_i;
   logic [6:0]        opcode_i;
   logic [3:0]        alusel_i;
   logic [2:0]        funct3_i;
   logic [6:0]        funct7_i;
   logic              flush_i;
   logic              valid_o;
   logic              ready_i;
   logic [DWIDTH-1:0] res_o;
   logic              brtaken_o;
   logic              busy_o;

   modport slave (
      input  valid_i, pc_i, rs1_i, rs2_i, imm_i, opcode_i, alusel_i,
             funct3_i, funct7_i, flush_i, ready_i,
      output ready_o, valid_o, res_o, brtaken_o, busy_o
   );

   modport master (
      output valid_i, pc_i, rs1_i, rs2_i, imm_i, opcode_i, alusel_i,
             funct3_i, funct7_i, flush_i, ready_i,
      input  ready_o, valid_o, res_o, brtaken_o, busy_o
   );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: RV32I ALU plus M-extension execute unit, one op in flight.
// Iterative radix-2 multiply/divide on operand magnitudes with sign fixup.
// Optional: define ALU_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
// dbg_state_o exposes the FSM state (0 IDLE, 1 MUL, 2 DIV, 3 DONE).
module alu_mdu #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_mdu_if.slave    bus_io,
   output logic [1:0]  dbg_state_o
);
   localparam int CW = $clog2(DWIDTH);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] ALU_OP_ADD    = 4'd0;
   localparam logic [3:0] ALU_OP_SUB    = 4'd1;
   localparam logic [3:0] ALU_OP_SLL    = 4'd2;
   localparam logic [3:0] ALU_OP_SLT    = 4'd3;
   localparam logic [3:0] ALU_OP_SLTU   = 4'd4;
   localparam logic [3:0] ALU_OP_XOR    = 4'd5;
   localparam logic [3:0] ALU_OP_SRL    = 4'd6;
   localparam logic [3:0] ALU_OP_SRA    = 4'd7;
   localparam logic [3:0] ALU_OP_OR     = 4'd8;
   localparam logic [3:0] ALU_OP_AND    = 4'd9;
   localparam logic [3:0] ALU_OP_COPY_B = 4'd10;

   localparam logic [DWIDTH-1:0] MIN_INT = {1'b1, {(DWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_e;

   state_e            state_q, state_d;
   logic [DWIDTH-1:0] acc_q, acc_d, lo_q, lo_d, opd_q, opd_d, res_q, res_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              neg_q, neg_d, hi_q, hi_d, brt_q, brt_d;

   logic [DWIDTH-1:0] pc_ext, op_a, op_b, alu_res, alu_out;
   logic [CW-1:0]     shamt;
   logic              br_taken, accept;
   logic              is_m, is_mul, is_div, a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
   logic [DWIDTH-1:0] mag_a, mag_b, div_spec, step_acc, step_lo, iter_res, iter_val;
   logic [DWIDTH:0]   mul_sum, div_trial;
   logic [2*DWIDTH-1:0] iter_full;

   assign pc_ext = DWIDTH'(bus_io.pc_i);
   assign shamt  = op_b[CW-1:0];

   // Operand selection by opcode class
   always_comb begin
      op_a = bus_io.rs1_i;
      op_b = bus_io.rs2_i;
      case (bus_io.opcode_i)
         OPC_LUI:                                 begin op_a = '0;            op_b = bus_io.imm_i; end
         OPC_AUIPC, OPC_JAL, OPC_BRANCH:          begin op_a = pc_ext;        op_b = bus_io.imm_i; end
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_STORE: begin op_a = bus_io.rs1_i; op_b = bus_io.imm_i; end
         default:                                 ;
      endcase
   end

   // Single-cycle ALU
   always_comb begin
      alu_res = '0;
      case (bus_io.alusel_i)
         ALU_OP_ADD:    alu_res = op_a + op_b;
         ALU_OP_SUB:    alu_res = op_a - op_b;
         ALU_OP_SLL:    alu_res = op_a << shamt;
         ALU_OP_SLT:    alu_res = {{(DWIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_OP_SLTU:   alu_res = {{(DWIDTH-1){1'b0}}, op_a < op_b};
         ALU_OP_XOR:    alu_res = op_a ^ op_b;
         ALU_OP_SRL:    alu_res = op_a >> shamt;
         ALU_OP_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
         ALU_OP_OR:     alu_res = op_a | op_b;
         ALU_OP_AND:    alu_res = op_a & op_b;
         ALU_OP_COPY_B: alu_res = op_b;
         default:       alu_res = '0;
      endcase
   end

   assign alu_out = (bus_io.opcode_i == OPC_JALR) ? {alu_res[DWIDTH-1:1], 1'b0} : alu_res;

   // Branch / jump decision on rs1/rs2
   always_comb begin
      br_taken = 1'b0;
      if (bus_io.opcode_i == OPC_BRANCH) begin
         case (bus_io.funct3_i)
            3'b000:  br_taken = (bus_io.rs1_i == bus_io.rs2_i);
            3'b001:  br_taken = (bus_io.rs1_i != bus_io.rs2_i);
            3'b100:  br_taken = ($signed(bus_io.rs1_i) <  $signed(bus_io.rs2_i));
            3'b101:  br_taken = ($signed(bus_io.rs1_i) >= $signed(bus_io.rs2_i));
            3'b110:  br_taken = (bus_io.rs1_i <  bus_io.rs2_i);
            3'b111:  br_taken = (bus_io.rs1_i >= bus_io.rs2_i);
            default: br_taken = 1'b0;
         endcase
      end else if (bus_io.opcode_i == OPC_JAL || bus_io.opcode_i == OPC_JALR) begin
         br_taken = 1'b1;
      end
   end

   // M-extension decode; funct3[2] splits multiply from divide
   assign is_m     = (bus_io.opcode_i == OPC_OP) && (bus_io.funct7_i == 7'b0000001);
   assign is_mul   = is_m && !bus_io.funct3_i[2];
   assign is_div   = is_m &&  bus_io.funct3_i[2];
   assign a_sgn    = is_div ? !bus_io.funct3_i[0]
                            : (bus_io.funct3_i[1:0] == 2'b01 || bus_io.funct3_i[1:0] == 2'b10);
   assign b_sgn    = is_div ? !bus_io.funct3_i[0] : (bus_io.funct3_i[1:0] == 2'b01);
   assign sa       = a_sgn & bus_io.rs1_i[DWIDTH-1];
   assign sb       = b_sgn & bus_io.rs2_i[DWIDTH-1];
   assign mag_a    = sa ? -bus_io.rs1_i : bus_io.rs1_i;
   assign mag_b    = sb ? -bus_io.rs2_i : bus_io.rs2_i;
   assign div_zero = (bus_io.rs2_i == '0);
   assign div_ovf  = !bus_io.funct3_i[0] && (bus_io.rs1_i == MIN_INT) && (bus_io.rs2_i == '1);
   // funct3[1] selects remainder over quotient
   assign div_spec = div_zero ? (bus_io.funct3_i[1] ? bus_io.rs1_i : '1)
                              : (bus_io.funct3_i[1] ? '0 : MIN_INT);

`ifdef ALU_MDU_FAST_MUL_EN
   logic [2*DWIDTH-1:0] fast_prod, fast_full;
   logic [DWIDTH-1:0]   fast_res;
   assign fast_prod = {{DWIDTH{1'b0}}, mag_a} * {{DWIDTH{1'b0}}, mag_b};
   assign fast_full = (sa ^ sb) ? -fast_prod : fast_prod;
   assign fast_res  = (bus_io.funct3_i[1:0] != 2'b00) ? fast_full[2*DWIDTH-1:DWIDTH]
                                                     : fast_full[DWIDTH-1:0];
`endif

   // One radix-2 iteration: shift-add for MUL, restore-or-keep for DIV
   assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
   assign div_trial = {acc_q, lo_q[DWIDTH-1]} - {1'b0, opd_q};

   // Iteration datapath and final sign fixup
   always_comb begin
      if (state_q == S_DIV) begin
         step_acc = div_trial[DWIDTH] ? {acc_q[DWIDTH-2:0], lo_q[DWIDTH-1]} : div_trial[DWIDTH-1:0];
         step_lo  = {lo_q[DWIDTH-2:0], ~div_trial[DWIDTH]};
      end else begin
         step_acc = mul_sum[DWIDTH:1];
         step_lo  = {mul_sum[0], lo_q[DWIDTH-1:1]};
      end
      iter_full = neg_q ? -{step_acc, step_lo} : {step_acc, step_lo};
      iter_val  = hi_q ? step_acc : step_lo;
      if (state_q == S_MUL) iter_res = hi_q ? iter_full[2*DWIDTH-1:DWIDTH] : iter_full[DWIDTH-1:0];
      else                  iter_res = neg_q ? -iter_val : iter_val;
   end

   assign bus_io.ready_o   = (state_q == S_IDLE) || (state_q == S_DONE && bus_io.ready_i);
   assign accept           = bus_io.valid_i && bus_io.ready_o && !bus_io.flush_i;
   assign bus_io.valid_o   = (state_q == S_DONE);
   assign bus_io.busy_o    = (state_q == S_MUL) || (state_q == S_DIV);
   assign bus_io.res_o     = res_q;
   assign bus_io.brtaken_o = brt_q;
   assign dbg_state_o      = state_q;

   // FSM next state and datapath loads; flush wins over everything
   always_comb begin
      state_d = state_q; acc_d = acc_q; lo_d = lo_q; opd_d = opd_q; cnt_d = cnt_q;
      neg_d   = neg_q;   hi_d  = hi_q;  res_d = res_q; brt_d = brt_q;
      if (bus_io.flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (state_q == S_DONE && bus_io.ready_i) state_d = S_IDLE;
               if (accept) begin
                  if (is_div) begin
                     if (div_zero || div_ovf) begin
                        res_d = div_spec; brt_d = 1'b0; state_d = S_DONE;
                     end else begin
                        acc_d = '0; lo_d = mag_a; opd_d = mag_b; cnt_d = '0;
                        neg_d = bus_io.funct3_i[1] ? sa : (sa ^ sb);
                        hi_d  = bus_io.funct3_i[1];
                        state_d = S_DIV;
                     end
                  end else if (is_mul) begin
`ifdef ALU_MDU_FAST_MUL_EN
                     res_d = fast_res; brt_d = 1'b0; state_d = S_DONE;
`else
                     acc_d = '0; lo_d = mag_b; opd_d = mag_a; cnt_d = '0;
                     neg_d = sa ^ sb;
                     hi_d  = (bus_io.funct3_i[1:0] != 2'b00);
                     state_d = S_MUL;
`endif
                  end else begin
                     res_d = alu_out; brt_d = br_taken; state_d = S_DONE;
                  end
               end
            end
            default: begin
               acc_d = step_acc; lo_d = step_lo; cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(DWIDTH-1)) begin
                  res_d = iter_res; brt_d = 1'b0; state_d = S_DONE;
               end
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE; acc_q <= '0; lo_q <= '0; opd_q <= '0; cnt_q <= '0;
         neg_q   <= 1'b0;   hi_q  <= 1'b0; res_q <= '0; brt_q <= 1'b0;
      end else begin
         state_q <= state_d; acc_q <= acc_d; lo_q <= lo_d; opd_q <= opd_d; cnt_q <= cnt_d;
         neg_q   <= neg_d;   hi_q  <= hi_d;  res_q <= res_d; brt_q <= brt_d;
      end
   end
endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed table, hand-written multi-cycle sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_alu_mdu;
   localparam int W = 32;
`ifdef ALU_MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                          JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                          STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4, XOR = 4'd5,
                          SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9, COPYB = 4'd10;
   localparam logic [6:0] M7 = 7'b0000001;

   typedef struct {
      logic [6:0]  opcode;
      logic [3:0]  alusel;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] pc, rs1, rs2, imm;
      logic [31:0] exp_res;
      logic        exp_brt;
      int          exp_lat;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [W-1:0] exp_q[$];
   vec_t       vecs[$];

   alu_mdu_if #(.DWIDTH(W), .AWIDTH(32)) bus_if ();

   alu_mdu #(.DWIDTH(W), .AWIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus_io(bus_if.slave), .dbg_state_o(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic [6:0] opc, logic [3:0] sel, logic [2:0] f3, logic [6:0] f7,
                               logic [31:0] pc, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                               logic [31:0] er, logic eb, int el);
      vec_t v;
      v.opcode = opc; v.alusel = sel; v.funct3 = f3; v.funct7 = f7;
      v.pc = pc; v.rs1 = a; v.rs2 = b; v.imm = imm;
      v.exp_res = er; v.exp_brt = eb; v.exp_lat = el;
      return v;
   endfunction

   // Reference model: RISC-V semantics in plain 64-bit arithmetic
   function automatic void ref_model(inout vec_t v);
      logic [31:0] a, b, r;
      longint      p;
      logic [63:0] u;
      int          sh;
      logic        brt;
      int          lat;
      r = '0; brt = 1'b0; lat = 1;
      if (v.opcode == OP && v.funct7 == M7) begin
         case (v.funct3)
            3'd0: begin p = longint'($signed(v.rs1)) * longint'($signed(v.rs2)); r = p[31:0];  lat = MUL_LAT; end
            3'd1: begin p = longint'($signed(v.rs1)) * longint'($signed(v.rs2)); r = p[63:32]; lat = MUL_LAT; end
            3'd2: begin p = longint'($signed(v.rs1)) * longint'({32'b0, v.rs2}); r = p[63:32]; lat = MUL_LAT; end
            3'd3: begin u = {32'b0, v.rs1} * {32'b0, v.rs2}; r = u[63:32]; lat = MUL_LAT; end
            3'd4: if (v.rs2 == 0) r = '1;
                  else if (v.rs1 == 32'h80000000 && v.rs2 == '1) r = 32'h80000000;
                  else begin r = 32'($signed(v.rs1) / $signed(v.rs2)); lat = DIV_LAT; end
            3'd5: if (v.rs2 == 0) r = '1; else begin r = v.rs1 / v.rs2; lat = DIV_LAT; end
            3'd6: if (v.rs2 == 0) r = v.rs1;
                  else if (v.rs1 == 32'h80000000 && v.rs2 == '1) r = 0;
                  else begin r = 32'($signed(v.rs1) % $signed(v.rs2)); lat = DIV_LAT; end
            default: if (v.rs2 == 0) r = v.rs1; else begin r = v.rs1 % v.rs2; lat = DIV_LAT; end
         endcase
      end else begin
         a = v.rs1; b = v.rs2;
         if (v.opcode == LUI) begin a = 0; b = v.imm; end
         else if (v.opcode == AUIPC || v.opcode == JAL || v.opcode == BRANCH) begin a = v.pc; b = v.imm; end
         else if (v.opcode == JALR || v.opcode == LOAD || v.opcode == OPIMM || v.opcode == STORE) b = v.imm;
         sh = int'(b % 32);
         case (v.alusel)
            ADD:   r = a + b;
            SUB:   r = a - b;
            SLL:   r = a << sh;
            SLT:   r = ($signed(a) < $signed(b)) ? 1 : 0;
            SLTU:  r = (a < b) ? 1 : 0;
            XOR:   r = a ^ b;
            SRL:   r = a >> sh;
            SRA:   r = $unsigned($signed(a) >>> sh);
            OR:    r = a | b;
            AND:   r = a & b;
            COPYB: r = b;
            default: r = 0;
         endcase
         if (v.opcode == JALR) r[0] = 1'b0;
         if (v.opcode == JAL || v.opcode == JALR) brt = 1'b1;
         if (v.opcode == BRANCH) begin
            case (v.funct3)
               3'd0: brt = (v.rs1 == v.rs2);
               3'd1: brt = (v.rs1 != v.rs2);
               3'd4: brt = ($signed(v.rs1) <  $signed(v.rs2));
               3'd5: brt = ($signed(v.rs1) >= $signed(v.rs2));
               3'd6: brt = (v.rs1 <  v.rs2);
               3'd7: brt = (v.rs1 >= v.rs2);
               default: brt = 1'b0;
            endcase
         end
      end
      v.exp_res = r; v.exp_brt = brt; v.exp_lat = lat;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      case ($urandom_range(0, 8))
         0: v.opcode = LUI;    1: v.opcode = AUIPC; 2: v.opcode = JAL;
         3: v.opcode = JALR;   4: v.opcode = BRANCH; 5: v.opcode = LOAD;
         6: v.opcode = STORE;  7: v.opcode = OPIMM;  default: v.opcode = OP;
      endcase
      v.alusel = 4'($urandom_range(0, 10));
      v.funct3 = 3'($urandom_range(0, 7));
      v.funct7 = (v.opcode == OP && $urandom_range(0, 2) != 0) ? M7 : 7'd0;
      v.pc = $urandom; v.rs1 = pick(); v.rs2 = pick(); v.imm = pick();
      ref_model(v);
      return v;
   endfunction

   // driver tasks
   task automatic drive(input vec_t v);
      bus_if.opcode_i = v.opcode; bus_if.alusel_i = v.alusel;
      bus_if.funct3_i = v.funct3; bus_if.funct7_i = v.funct7;
      bus_if.pc_i = v.pc; bus_if.rs1_i = v.rs1; bus_if.rs2_i = v.rs2; bus_if.imm_i = v.imm;
   endtask

   task automatic run_op(input vec_t v, input bit scramble, input string name);
      int lat;
      @(negedge clk);
      drive(v);
      bus_if.valid_i = 1'b1; bus_if.ready_i = 1'b1;
      check($sformatf("%s.ready", name), 32'(bus_if.ready_o), 32'd1);
      exp_q.push_back(v.exp_res);
      @(negedge clk);
      bus_if.valid_i = 1'b0;
      if (scramble) begin
         bus_if.rs1_i = $urandom; bus_if.rs2_i = $urandom; bus_if.funct3_i = 3'($urandom);
      end
      lat = 1;
      while (!bus_if.valid_o && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("%s.latency", name), 32'(lat), 32'(v.exp_lat));
      check($sformatf("%s.res", name), bus_if.res_o, exp_q.pop_front());
      check($sformatf("%s.brtaken", name), 32'(bus_if.brtaken_o), 32'(v.exp_brt));
   endtask

   initial begin
      vec_t v;
      bus_if.valid_i = 0; bus_if.ready_i = 1; bus_if.flush_i = 0;
      bus_if.pc_i = 0; bus_if.rs1_i = 0; bus_if.rs2_i = 0; bus_if.imm_i = 0;
      bus_if.opcode_i = OP; bus_if.alusel_i = ADD; bus_if.funct3_i = 0; bus_if.funct7_i = 0;

      // reset
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset.ready_o", 32'(bus_if.ready_o), 32'd1);
      check("reset.valid_o", 32'(bus_if.valid_o), 32'd0);
      check("reset.res_o", bus_if.res_o, 32'd0);
      check("reset.brtaken_o", 32'(bus_if.brtaken_o), 32'd0);
      check("reset.busy_o", 32'(bus_if.busy_o), 32'd0);
      check("reset.state", 32'(dbg_state), 32'd0);

      // back-to-back ADD then SUB with no bubble
      drive(mk(OP, ADD, 0, 0, 0, 5, 7, 0, 0, 0, 1));
      bus_if.valid_i = 1; bus_if.ready_i = 1;
      @(negedge clk);
      check("b2b.add_valid", 32'(bus_if.valid_o), 32'd1);
      check("b2b.add_res", bus_if.res_o, 32'd12);
      check("b2b.ready_in_done", 32'(bus_if.ready_o), 32'd1);
      drive(mk(OP, SUB, 0, 0, 0, 20, 5, 0, 0, 0, 1));
      @(negedge clk);
      check("b2b.sub_valid", 32'(bus_if.valid_o), 32'd1);
      check("b2b.sub_res", bus_if.res_o, 32'd15);
      bus_if.valid_i = 0;
      @(negedge clk);
      check("b2b.drain_valid", 32'(bus_if.valid_o), 32'd0);

      // directed table
      vecs.push_back(mk(OP,     ADD,  0, 0,  0, 5, 7, 0, 32'd12, 0, 1));
      vecs.push_back(mk(OP,     SUB,  0, 0,  0, 5, 7, 0, 32'hFFFFFFFE, 0, 1));
      vecs.push_back(mk(OPIMM,  SLT,  0, 0,  0, 32'hFFFFFFFD, 99, 2, 32'd1, 0, 1));
      vecs.push_back(mk(OP,     SLTU, 0, 0,  0, 32'hFFFFFFFD, 2, 0, 32'd0, 0, 1));
      vecs.push_back(mk(OP,     SRA,  0, 0,  0, 32'h80000000, 32'h24, 0, 32'hF8000000, 0, 1));
      vecs.push_back(mk(OP,     SRL,  0, 0,  0, 32'h80000000, 32'h24, 0, 32'h08000000, 0, 1));
      vecs.push_back(mk(OP,     SLL,  0, 0,  0, 1, 31, 0, 32'h80000000, 0, 1));
      vecs.push_back(mk(OP,     XOR,  0, 0,  0, 32'hF0F0, 32'hFF00, 0, 32'h0FF0, 0, 1));
      vecs.push_back(mk(OP,     OR,   0, 0,  0, 32'hF0F0, 32'hFF00, 0, 32'hFFF0, 0, 1));
      vecs.push_back(mk(OP,     AND,  0, 0,  0, 32'hF0F0, 32'hFF00, 0, 32'hF000, 0, 1));
      vecs.push_back(mk(LUI,    ADD,  0, 0,  0, 32'hDEADBEEF, 0, 32'h12345000, 32'h12345000, 0, 1));
      vecs.push_back(mk(AUIPC,  ADD,  0, 0,  32'h1000, 0, 0, 32'h20, 32'h1020, 0, 1));
      vecs.push_back(mk(JAL,    ADD,  0, 0,  32'h1000, 0, 0, 8, 32'h1008, 1, 1));
      vecs.push_back(mk(JALR,   ADD,  0, 0,  0, 32'h2003, 0, 32'h10, 32'h2012, 1, 1));
      vecs.push_back(mk(BRANCH, ADD,  4, 0,  32'h100, 32'hFFFFFFFF, 1, 32'h40, 32'h140, 1, 1));
      vecs.push_back(mk(BRANCH, ADD,  6, 0,  32'h100, 32'hFFFFFFFF, 1, 32'h40, 32'h140, 0, 1));
      vecs.push_back(mk(BRANCH, ADD,  0, 0,  32'h100, 7, 7, 32'h40, 32'h140, 1, 1));
      vecs.push_back(mk(BRANCH, ADD,  7, 0,  32'h100, 5, 5, 32'h40, 32'h140, 1, 1));
      vecs.push_back(mk(STORE,  COPYB,0, 0,  0, 3, 4, 32'h55, 32'h55, 0, 1));
      vecs.push_back(mk(OP,     ADD,  1, M7, 0, 32'h80000000, 32'h80000000, 0, 32'h40000000, 0, MUL_LAT));
      vecs.push_back(mk(OP,     ADD,  0, M7, 0, 6, 32'hFFFFFFF9, 0, 32'hFFFFFFD6, 0, MUL_LAT));
      vecs.push_back(mk(OP,     ADD,  3, M7, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 0, MUL_LAT));
      vecs.push_back(mk(OP,     ADD,  2, M7, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, MUL_LAT));
      vecs.push_back(mk(OP,     ADD,  4, M7, 0, 32'hFFFFFFF9, 2, 0, 32'hFFFFFFFD, 0, DIV_LAT));
      vecs.push_back(mk(OP,     ADD,  6, M7, 0, 32'hFFFFFFF9, 2, 0, 32'hFFFFFFFF, 0, DIV_LAT));
      vecs.push_back(mk(OP,     ADD,  6, M7, 0, 7, 32'hFFFFFFFE, 0, 32'd1, 0, DIV_LAT));
      vecs.push_back(mk(OP,     ADD,  5, M7, 0, 9, 0, 0, 32'hFFFFFFFF, 0, 1));
      vecs.push_back(mk(OP,     ADD,  7, M7, 0, 9, 0, 0, 32'd9, 0, 1));
      vecs.push_back(mk(OP,     ADD,  4, M7, 0, 9, 0, 0, 32'hFFFFFFFF, 0, 1));
      vecs.push_back(mk(OP,     ADD,  4, M7, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 1));
      vecs.push_back(mk(OP,     ADD,  6, M7, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, 0, 1));
      vecs.push_back(mk(OP,     ADD,  5, M7, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'd0, 0, DIV_LAT));
      vecs.push_back(mk(OP,     ADD,  7, M7, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, DIV_LAT));
      for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

      // operands change after accept must not disturb an iterative divide
      run_op(mk(OP, ADD, 5, M7, 0, 100, 7, 0, 32'd14, 0, DIV_LAT), 1'b1, "div_hold_operands");

      // randomized ops against the reference model
      for (int i = 0; i < 80; i++) begin
         v = rand_vec();
         run_op(v, 1'b0, $sformatf("rand%0d", i));
      end

      // backpressure: result held for 5 stalled cycles, then exactly one transfer
      @(negedge clk);
      drive(mk(OP, XOR, 0, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 0, 1));
      bus_if.valid_i = 1; bus_if.ready_i = 0;
      @(negedge clk);
      check("bp.first_valid", 32'(bus_if.valid_o), 32'd1);
      drive(mk(OP, ADD, 0, 0, 0, 1, 1, 0, 0, 0, 1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp.valid%0d", i), 32'(bus_if.valid_o), 32'd1);
         check($sformatf("bp.res%0d", i), bus_if.res_o, 32'h0FF0);
         check($sformatf("bp.ready_o%0d", i), 32'(bus_if.ready_o), 32'd0);
      end
      bus_if.ready_i = 1;
      #1;
      check("bp.ready_o_release", 32'(bus_if.ready_o), 32'd1);
      @(negedge clk);
      bus_if.valid_i = 0;
      check("bp.next_valid", 32'(bus_if.valid_o), 32'd1);
      check("bp.next_res", bus_if.res_o, 32'd2);
      @(negedge clk);
      check("bp.drained", 32'(bus_if.valid_o), 32'd0);

      // flush at cycle N+10 of a divide, with a competing request that cycle
      drive(mk(OP, ADD, 4, M7, 0, 1000, 3, 0, 0, 0, 1));
      bus_if.valid_i = 1; bus_if.ready_i = 1;
      @(negedge clk);
      bus_if.valid_i = 0;
      repeat (9) @(negedge clk);
      check("flush.busy_before", 32'(bus_if.busy_o), 32'd1);
      check("flush.valid_before", 32'(bus_if.valid_o), 32'd0);
      drive(mk(OP, ADD, 0, 0, 0, 3, 4, 0, 0, 0, 1));
      bus_if.valid_i = 1; bus_if.flush_i = 1;
      @(negedge clk);
      bus_if.valid_i = 0; bus_if.flush_i = 0;
      check("flush.valid", 32'(bus_if.valid_o), 32'd0);
      check("flush.busy", 32'(bus_if.busy_o), 32'd0);
      check("flush.ready_o", 32'(bus_if.ready_o), 32'd1);
      check("flush.state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      check("flush.req_not_accepted", 32'(bus_if.valid_o), 32'd0);
      repeat (30) @(negedge clk);
      check("flush.div_dropped", 32'(bus_if.valid_o), 32'd0);

      // asynchronous reset in the middle of a multiply
      drive(mk(OP, ADD, 0, M7, 0, 3, 5, 0, 0, 0, 1));
      bus_if.valid_i = 1; bus_if.ready_i = 1;
      @(negedge clk);
      bus_if.valid_i = 0;
      repeat (4) @(negedge clk);
      rst_n = 0;
      #1;
      check("rst.valid_o", 32'(bus_if.valid_o), 32'd0);
      check("rst.res_o", bus_if.res_o, 32'd0);
      check("rst.brtaken_o", 32'(bus_if.brtaken_o), 32'd0);
      check("rst.busy_o", 32'(bus_if.busy_o), 32'd0);
      check("rst.ready_o", 32'(bus_if.ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1;
      repeat (40) @(negedge clk);
      check("rst.no_result", 32'(bus_if.valid_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
